// File: rtl/uart_cmd_parser_pkg.sv
// rtl/uart_cmd_parser_pkg.sv - shared constants and state encoding for the UART command parser
//
// Purpose: ASCII command/terminator bytes, the 3-bit FSM state encoding and a
//          small end-of-line helper, shared by the parser top and its bench.
// Ports:   none (package).
package uart_cmd_parser_pkg;

  localparam logic [7:0] ASCII_W_UC = 8'h57;  // 'W'
  localparam logic [7:0] ASCII_W_LC = 8'h77;  // 'w'
  localparam logic [7:0] ASCII_R_UC = 8'h52;  // 'R'
  localparam logic [7:0] ASCII_R_LC = 8'h72;  // 'r'
  localparam logic [7:0] ASCII_CR   = 8'h0D;
  localparam logic [7:0] ASCII_LF   = 8'h0A;

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_ADDR_HI = 3'd1;
  localparam logic [2:0] ST_ADDR_LO = 3'd2;
  localparam logic [2:0] ST_DATA_HI = 3'd3;
  localparam logic [2:0] ST_DATA_LO = 3'd4;
  localparam logic [2:0] ST_EOL     = 3'd5;
  localparam logic [2:0] ST_DISCARD = 3'd6;

  typedef enum logic [2:0] {
    S_IDLE    = ST_IDLE,
    S_ADDR_HI = ST_ADDR_HI,
    S_ADDR_LO = ST_ADDR_LO,
    S_DATA_HI = ST_DATA_HI,
    S_DATA_LO = ST_DATA_LO,
    S_EOL     = ST_EOL,
    S_DISCARD = ST_DISCARD
  } state_e;

  function automatic logic is_eol(input logic [7:0] b);
    return (b == ASCII_CR) || (b == ASCII_LF);
  endfunction

endpackage

// File: rtl/uart_cmd_parser_hex_nibble.sv
// rtl/uart_cmd_parser_hex_nibble.sv - combinational ASCII hex digit decoder
//
// Purpose: maps '0'-'9', 'A'-'F', 'a'-'f' to 0-15 and flags any other byte.
// Ports:
//   byte_i    in  8  candidate ASCII byte
//   valid_o   out 1  byte is a hex digit
//   nibble_o  out 4  decoded value (0 when not valid)
module hex_nibble (
  input  logic [7:0] byte_i,
  output logic       valid_o,
  output logic [3:0] nibble_o
);

  always_comb begin
    valid_o  = 1'b0;
    nibble_o = 4'h0;
    if (byte_i >= 8'h30 && byte_i <= 8'h39) begin
      valid_o  = 1'b1;
      nibble_o = byte_i[3:0];
    end else if ((byte_i >= 8'h41 && byte_i <= 8'h46) ||
                 (byte_i >= 8'h61 && byte_i <= 8'h66)) begin
      // Low nibble of 'A'/'a' is 1, so adding 9 lands on 10.
      valid_o  = 1'b1;
      nibble_o = byte_i[3:0] + 4'd9;
    end
  end

endmodule

// File: rtl/uart_cmd_parser.sv
// rtl/uart_cmd_parser.sv - ASCII Waadd/Raa command decoder behind the UART receiver
//
// Purpose: parses "Waadd<EOL>" and "Raa<EOL>" from the received byte stream,
//          issues one-cycle wr/rd strobes with held addr/wdata, flags syntax
//          errors and inter-byte timeouts, and resynchronises at end-of-line.
// Ports:
//   clk    in  1  system clock
//   rstn   in  1  synchronous active-low reset
//   rcv    in  1  one-cycle pulse, data is valid
//   data   in  8  received byte
//   wr     out 1  one-cycle write strobe
//   rd     out 1  one-cycle read strobe
//   addr   out 8  address of the last completed command
//   wdata  out 8  data of the last completed write
//   err    out 1  one-cycle syntax-error / timeout pulse
//   busy   out 1  command partially received
module uart_cmd_parser
  import uart_cmd_parser_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 120000
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       rcv,
  input  logic [7:0] data,
  output logic       wr,
  output logic       rd,
  output logic [7:0] addr,
  output logic [7:0] wdata,
  output logic       err,
  output logic       busy
);

  localparam int CW = $clog2(TIMEOUT_CYCLES);
  localparam logic [CW-1:0] CNT_MAX = CW'(TIMEOUT_CYCLES - 1);

  state_e        state_q, state_d;
  logic          cmd_wr_q, cmd_wr_d;
  logic [7:0]    sh_addr_q, sh_addr_d;
  logic [7:0]    sh_wdata_q, sh_wdata_d;
  logic [7:0]    addr_q, addr_d;
  logic [7:0]    wdata_q, wdata_d;
  logic          wr_q, wr_d;
  logic          rd_q, rd_d;
  logic          err_q, err_d;
  logic          busy_q, busy_d;
  logic [CW-1:0] cnt_q, cnt_d;

  logic       hex_valid;
  logic [3:0] hex_val;
  logic       timed;

  hex_nibble u_hex (
    .byte_i   (data),
    .valid_o  (hex_valid),
    .nibble_o (hex_val)
  );

  // Only the partially-received states are subject to the inter-byte timeout.
  assign timed = (state_q == S_ADDR_HI) || (state_q == S_ADDR_LO) ||
                 (state_q == S_DATA_HI) || (state_q == S_DATA_LO) ||
                 (state_q == S_EOL);

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q    <= S_IDLE;
      cmd_wr_q   <= 1'b0;
      sh_addr_q  <= 8'h00;
      sh_wdata_q <= 8'h00;
      addr_q     <= 8'h00;
      wdata_q    <= 8'h00;
      wr_q       <= 1'b0;
      rd_q       <= 1'b0;
      err_q      <= 1'b0;
      busy_q     <= 1'b0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      cmd_wr_q   <= cmd_wr_d;
      sh_addr_q  <= sh_addr_d;
      sh_wdata_q <= sh_wdata_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      wr_q       <= wr_d;
      rd_q       <= rd_d;
      err_q      <= err_d;
      busy_q     <= busy_d;
      cnt_q      <= cnt_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    cmd_wr_d   = cmd_wr_q;
    sh_addr_d  = sh_addr_q;
    sh_wdata_d = sh_wdata_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    wr_d       = 1'b0;
    rd_d       = 1'b0;
    err_d      = 1'b0;

    if (rcv) begin
      case (state_q)
        S_IDLE: begin
          if (data == ASCII_W_UC || data == ASCII_W_LC) begin
            cmd_wr_d = 1'b1;
            state_d  = S_ADDR_HI;
          end else if (data == ASCII_R_UC || data == ASCII_R_LC) begin
            cmd_wr_d = 1'b0;
            state_d  = S_ADDR_HI;
          end else if (!is_eol(data)) begin
            err_d   = 1'b1;
            state_d = S_DISCARD;
          end
        end
        S_ADDR_HI, S_ADDR_LO, S_DATA_HI, S_DATA_LO: begin
          if (hex_valid) begin
            case (state_q)
              S_ADDR_HI: begin
                sh_addr_d[7:4] = hex_val;
                state_d        = S_ADDR_LO;
              end
              S_ADDR_LO: begin
                sh_addr_d[3:0] = hex_val;
                state_d        = cmd_wr_q ? S_DATA_HI : S_EOL;
              end
              S_DATA_HI: begin
                sh_wdata_d[7:4] = hex_val;
                state_d         = S_DATA_LO;
              end
              default: begin
                sh_wdata_d[3:0] = hex_val;
                state_d         = S_EOL;
              end
            endcase
          end else begin
            // An early terminator already resynchronises, so skip DISCARD.
            err_d   = 1'b1;
            state_d = is_eol(data) ? S_IDLE : S_DISCARD;
          end
        end
        S_EOL: begin
          if (is_eol(data)) begin
            addr_d  = sh_addr_q;
            state_d = S_IDLE;
            if (cmd_wr_q) begin
              wdata_d = sh_wdata_q;
              wr_d    = 1'b1;
            end else begin
              rd_d = 1'b1;
            end
          end else begin
            err_d   = 1'b1;
            state_d = S_DISCARD;
          end
        end
        S_DISCARD: begin
          if (is_eol(data)) state_d = S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase
    end else if (timed && cnt_q == CNT_MAX) begin
      err_d   = 1'b1;
      state_d = S_IDLE;
    end
  end

  // Saturating idle counter; any received byte or return to IDLE restarts it.
  always_comb begin
    cnt_d = cnt_q;
    if (rcv || state_d == S_IDLE || !timed) begin
      cnt_d = '0;
    end else if (cnt_q != CNT_MAX) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  assign busy_d = (state_d != S_IDLE) && (state_d != S_DISCARD);

  assign wr    = wr_q;
  assign rd    = rd_q;
  assign err   = err_q;
  assign busy  = busy_q;
  assign addr  = addr_q;
  assign wdata = wdata_q;

endmodule

// File: tb/tb_uart_cmd_parser.sv
// tb/tb_uart_cmd_parser.sv - self-checking bench for uart_cmd_parser
module tb_uart_cmd_parser;

  localparam int TO = 50;

  logic       clk = 1'b0;
  logic       rstn;
  logic       rcv;
  logic [7:0] data;
  logic       wr, rd, err, busy;
  logic [7:0] addr, wdata;

  int n_checks = 0;
  int n_pass   = 0;

  typedef struct {
    logic [7:0]  d;
    int          gap;
    logic [19:0] exp;   // {wr, rd, err, busy, addr, wdata}
  } vec_t;

  vec_t tbl[$];

  uart_cmd_parser #(.TIMEOUT_CYCLES(TO)) dut (
    .clk   (clk),
    .rstn  (rstn),
    .rcv   (rcv),
    .data  (data),
    .wr    (wr),
    .rd    (rd),
    .addr  (addr),
    .wdata (wdata),
    .err   (err),
    .busy  (busy)
  );

  always #5 clk = ~clk;

  function automatic logic [19:0] E(input logic w, input logic r, input logic e,
                                    input logic b, input logic [7:0] a,
                                    input logic [7:0] wd);
    return {w, r, e, b, a, wd};
  endfunction

  function automatic vec_t mk(input logic [7:0] d, input int gap, input logic [19:0] exp);
    vec_t v;
    v.d = d; v.gap = gap; v.exp = exp;
    return v;
  endfunction

  task automatic check(input string name, input logic [19:0] exp);
    logic [19:0] got;
    got = {wr, rd, err, busy, addr, wdata};
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got wr/rd/err/busy=%b addr=%h wdata=%h, want wr/rd/err/busy=%b addr=%h wdata=%h",
                  name, got[19:16], got[15:8], got[7:0], exp[19:16], exp[15:8], exp[7:0]);
  endtask

  // Drive one byte, check outputs after the edge that consumes it, then idle
  // for gap cycles checking that the strobes were single-cycle.
  task automatic step(input string name, input logic [7:0] d, input int gap,
                      input logic [19:0] exp);
    @(negedge clk);
    rcv  = 1'b1;
    data = d;
    @(posedge clk);
    #1;
    check(name, exp);
    for (int g = 0; g < gap; g++) begin
      @(negedge clk);
      rcv = 1'b0;
      @(posedge clk);
      #1;
      if (g == 0) begin
        n_checks++;
        if ({wr, rd, err} === 3'b000) n_pass++;
        else $display("FAIL %s_pulse: got wr/rd/err=%b, want 000", name, {wr, rd, err});
      end
    end
  endtask

  initial begin
    int first_err;
    int err_cnt;

    rstn = 1'b0;
    rcv  = 1'b0;
    data = 8'h00;
    repeat (2) @(posedge clk);
    #1;
    check("reset", E(0, 0, 0, 0, 8'h00, 8'h00));
    @(negedge clk);
    rstn = 1'b1;

    // W3fA5 CR
    tbl.push_back(mk("W", 1, E(0, 0, 0, 1, 8'h00, 8'h00)));
    tbl.push_back(mk("3", 1, E(0, 0, 0, 1, 8'h00, 8'h00)));
    tbl.push_back(mk("f", 1, E(0, 0, 0, 1, 8'h00, 8'h00)));
    tbl.push_back(mk("A", 1, E(0, 0, 0, 1, 8'h00, 8'h00)));
    tbl.push_back(mk("5", 1, E(0, 0, 0, 1, 8'h00, 8'h00)));
    tbl.push_back(mk(8'h0D, 1, E(1, 0, 0, 0, 8'h3F, 8'hA5)));
    // r07 LF, trailing CR
    tbl.push_back(mk("r", 1, E(0, 0, 0, 1, 8'h3F, 8'hA5)));
    tbl.push_back(mk("0", 1, E(0, 0, 0, 1, 8'h3F, 8'hA5)));
    tbl.push_back(mk("7", 1, E(0, 0, 0, 1, 8'h3F, 8'hA5)));
    tbl.push_back(mk(8'h0A, 1, E(0, 1, 0, 0, 8'h07, 8'hA5)));
    tbl.push_back(mk(8'h0D, 1, E(0, 0, 0, 0, 8'h07, 8'hA5)));
    // W1G23 CR -> error, then R22 CR
    tbl.push_back(mk("W", 1, E(0, 0, 0, 1, 8'h07, 8'hA5)));
    tbl.push_back(mk("1", 1, E(0, 0, 0, 1, 8'h07, 8'hA5)));
    tbl.push_back(mk("G", 1, E(0, 0, 1, 0, 8'h07, 8'hA5)));
    tbl.push_back(mk("2", 1, E(0, 0, 0, 0, 8'h07, 8'hA5)));
    tbl.push_back(mk("3", 1, E(0, 0, 0, 0, 8'h07, 8'hA5)));
    tbl.push_back(mk(8'h0D, 1, E(0, 0, 0, 0, 8'h07, 8'hA5)));
    tbl.push_back(mk("R", 1, E(0, 0, 0, 1, 8'h07, 8'hA5)));
    tbl.push_back(mk("2", 1, E(0, 0, 0, 1, 8'h07, 8'hA5)));
    tbl.push_back(mk("2", 1, E(0, 0, 0, 1, 8'h07, 8'hA5)));
    tbl.push_back(mk(8'h0D, 1, E(0, 1, 0, 0, 8'h22, 8'hA5)));
    // back-to-back W00FF CR
    tbl.push_back(mk("W", 0, E(0, 0, 0, 1, 8'h22, 8'hA5)));
    tbl.push_back(mk("0", 0, E(0, 0, 0, 1, 8'h22, 8'hA5)));
    tbl.push_back(mk("0", 0, E(0, 0, 0, 1, 8'h22, 8'hA5)));
    tbl.push_back(mk("F", 0, E(0, 0, 0, 1, 8'h22, 8'hA5)));
    tbl.push_back(mk("F", 0, E(0, 0, 0, 1, 8'h22, 8'hA5)));
    tbl.push_back(mk(8'h0D, 1, E(1, 0, 0, 0, 8'h00, 8'hFF)));
    // non-EOL in EOL state
    tbl.push_back(mk("R", 1, E(0, 0, 0, 1, 8'h00, 8'hFF)));
    tbl.push_back(mk("1", 1, E(0, 0, 0, 1, 8'h00, 8'hFF)));
    tbl.push_back(mk("2", 1, E(0, 0, 0, 1, 8'h00, 8'hFF)));
    tbl.push_back(mk("3", 1, E(0, 0, 1, 0, 8'h00, 8'hFF)));
    tbl.push_back(mk(8'h0D, 1, E(0, 0, 0, 0, 8'h00, 8'hFF)));
    // early EOL goes straight to IDLE
    tbl.push_back(mk("W", 1, E(0, 0, 0, 1, 8'h00, 8'hFF)));
    tbl.push_back(mk("1", 1, E(0, 0, 0, 1, 8'h00, 8'hFF)));
    tbl.push_back(mk(8'h0D, 1, E(0, 0, 1, 0, 8'h00, 8'hFF)));
    tbl.push_back(mk("R", 1, E(0, 0, 0, 1, 8'h00, 8'hFF)));
    tbl.push_back(mk("A", 1, E(0, 0, 0, 1, 8'h00, 8'hFF)));
    tbl.push_back(mk("b", 1, E(0, 0, 0, 1, 8'h00, 8'hFF)));
    tbl.push_back(mk(8'h0A, 1, E(0, 1, 0, 0, 8'hAB, 8'hFF)));
    // bad letter, DISCARD swallows everything up to EOL without more errors
    tbl.push_back(mk("x", 1, E(0, 0, 1, 0, 8'hAB, 8'hFF)));
    tbl.push_back(mk("W", 1, E(0, 0, 0, 0, 8'hAB, 8'hFF)));
    tbl.push_back(mk(8'h0D, 1, E(0, 0, 0, 0, 8'hAB, 8'hFF)));

    foreach (tbl[i]) step($sformatf("vec%0d", i), tbl[i].d, tbl[i].gap, tbl[i].exp);

    // Timeout: W12 then silence
    step("to_W", "W", 0, E(0, 0, 0, 1, 8'hAB, 8'hFF));
    step("to_1", "1", 0, E(0, 0, 0, 1, 8'hAB, 8'hFF));
    step("to_2", "2", 0, E(0, 0, 0, 1, 8'hAB, 8'hFF));
    first_err = -1;
    err_cnt   = 0;
    for (int n = 1; n <= TO + 10; n++) begin
      @(negedge clk);
      rcv = 1'b0;
      @(posedge clk);
      #1;
      if (err) begin
        err_cnt++;
        if (first_err < 0) first_err = n;
      end
    end
    n_checks++;
    if (first_err == TO) n_pass++;
    else $display("FAIL timeout_cycle: got %0d, want %0d", first_err, TO);
    n_checks++;
    if (err_cnt == 1) n_pass++;
    else $display("FAIL timeout_count: got %0d, want 1", err_cnt);
    check("timeout_after", E(0, 0, 0, 0, 8'hAB, 8'hFF));
    step("post_to_R", "R", 1, E(0, 0, 0, 1, 8'hAB, 8'hFF));
    step("post_to_5a", "5", 1, E(0, 0, 0, 1, 8'hAB, 8'hFF));
    step("post_to_5b", "5", 1, E(0, 0, 0, 1, 8'hAB, 8'hFF));
    step("post_to_cr", 8'h0D, 1, E(0, 1, 0, 0, 8'h55, 8'hFF));

    // Reset mid-command
    step("rst_R", "R", 1, E(0, 0, 0, 1, 8'h55, 8'hFF));
    step("rst_1", "1", 1, E(0, 0, 0, 1, 8'h55, 8'hFF));
    @(negedge clk);
    rcv  = 1'b0;
    rstn = 1'b0;
    @(posedge clk);
    #1;
    check("mid_reset", E(0, 0, 0, 0, 8'h00, 8'h00));
    @(negedge clk);
    rstn = 1'b1;
    step("rst_5", "5", 1, E(0, 0, 1, 0, 8'h00, 8'h00));
    step("rst_cr", 8'h0D, 1, E(0, 0, 0, 0, 8'h00, 8'h00));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/uart_cmd_parser.md
# uart_cmd_parser

Byte-stream command decoder placed directly downstream of the UART receiver. Consumes the receiver's one-cycle `rcv` pulse and `data` byte, parses ASCII commands `Waadd<EOL>` (write) and `Raa<EOL>` (read), where `aa` and `dd` are two hex digits each. Emits a one-cycle write or read strobe with address and data held stable for the register bank. Malformed input and stalled lines are flagged and resynchronised at the next end-of-line.

## Interface
- `TIMEOUT_CYCLES`, default 120000 (10 ms at 12 MHz): idle clocks allowed between bytes of one command; must be ≥ 2.
- `clk`  in  1  system clock.
- `rstn`  in  1  reset, synchronous, active-low.
- `rcv`  in  1  one-cycle pulse: byte on `data` is valid.
- `data`  in  8  received byte, sampled only when `rcv`=1.
- `wr`  out  1  one-cycle write strobe.
- `rd`  out  1  one-cycle read strobe.
- `addr`  out  8  command address; updated only in the cycle `wr`/`rd` rises, held otherwise.
- `wdata`  out  8  write data; updated only with `wr`, held otherwise.
- `err`  out  1  one-cycle pulse on syntax error or timeout.
- `busy`  out  1  high while a command is partially received (state ≠ IDLE, DISCARD).

## Operation
- Hex digit: `0`-`9`, `A`-`F`, `a`-`f`, mapping to 0-15. EOL: CR (0x0D) or LF (0x0A).
- States: IDLE, ADDR_HI, ADDR_LO, DATA_HI, DATA_LO, EOL, DISCARD. Transitions occur only on `rcv`, except on timeout.
- IDLE:
  - `W`/`w` → ADDR_HI with cmd=W.
  - `R`/`r` → ADDR_HI with cmd=R.
  - EOL → stay IDLE silently (CR+LF pairs are harmless).
  - Any other byte → `err`, go to DISCARD.
- ADDR_HI: hex → shadow addr[7:4], go to ADDR_LO.
- ADDR_LO: hex → addr[3:0]; if cmd=R go to EOL, if cmd=W go to DATA_HI.
- DATA_HI / DATA_LO: hex → wdata[7:4] / [3:0]; DATA_LO goes to EOL.
- Any non-hex byte in ADDR_*/DATA_* → `err`, go to DISCARD. If that byte is itself EOL, go to IDLE instead.
- EOL state:
  - EOL byte → copy shadow regs to outputs, pulse `wr` or `rd`, go to IDLE.
  - Any other byte → `err`, go to DISCARD.
- DISCARD: ignore bytes until EOL, then IDLE. No further `err` pulses.
- Timeout: the counter clears on every `rcv` and on entry to IDLE. In ADDR_HI..EOL, when it reaches TIMEOUT_CYCLES-1 without `rcv`, pulse `err` and go to IDLE. DISCARD has no timeout.
- A partial command never modifies `addr`/`wdata` outputs.

## Timing
- Reset: state=IDLE; `wr`, `rd`, `err`, `busy`=0; `addr`, `wdata`=0x00; counter=0. Reset mid-command discards it with no strobe.
- Latency: `wr`/`rd`/`err` are registered and assert in the cycle after the `rcv` cycle of the triggering byte. `addr`/`wdata` change on that same edge.
- `busy` is registered from state and rises the cycle after the command letter's `rcv`.
- A timeout and `rcv` in the same cycle: `rcv` wins and the byte is processed normally.
- `wr` and `rd` are never high together. At most one of `wr`/`rd`/`err` asserts per cycle.
- No backpressure. Consecutive `rcv` pulses one cycle apart must be handled.
- Counter width is $clog2(TIMEOUT_CYCLES); it saturates and never wraps.

## Structure
- Shared package holds ASCII constants (W, w, R, r, CR, LF) and the state encoding localparams (3-bit).
- Sub-module `hex_nibble`: combinational byte → {valid, nibble[3:0]}, one instance.
- The top level contains the FSM, shadow registers, output registers and timeout counter.

## Test plan
- `W`,`3`,`f`,`A`,`5`,CR → single `wr`, addr=0x3F, wdata=0xA5, no `err`; `busy` low afterwards.
- `r`,`0`,`7`,LF followed by an extra CR → single `rd`, addr=0x07, wdata unchanged, no `err` from the trailing CR.
- `W`,`1`,`G`,`2`,`3`,CR → one `err` on `G`, no strobe, back in IDLE after CR; then `R`,`2`,`2`,CR → `rd`, addr=0x22.
- `W`,`1`,`2`, then silence for TIMEOUT_CYCLES (small value, e.g. 50, in the bench) → `err` exactly once, state IDLE, addr/wdata unchanged.
- Back-to-back `rcv` every cycle for `W00FF`,CR → `wr`, wdata=0xFF. Separately, assert rstn=0 after `R`,`1` → all outputs 0, and a subsequent `5`,CR produces only `err` (bad command letter).
